avalon_st_seq_source: RTL and testbench
=======================================

AVALON_ST_SEQ_SOURCE -- requirements
Module: avalon_st_seq_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of data in bits (1..32).
REQ-002 SHALL have parameter PKT_LEN, default 3, meaning beats per packet (1..255).
REQ-003 SHALL have parameter START_VAL, default 4, meaning data value of the first beat of every packet.
REQ-004 SHALL have parameter STEP, default 1, meaning increment added per beat.
REQ-005 SHALL have parameter NUM_PKTS, default 1, meaning packets per run (0 = unlimited, never reaches DONE).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL have port resetn, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, meaning run request, sampled in IDLE or DONE only.
REQ-009 SHALL have port ready, input, 1, meaning Avalon-ST sink ready, readyLatency 0.
REQ-010 SHALL have port valid, output, 1, meaning Avalon-ST valid.
REQ-011 SHALL have port data, output, DATA_WIDTH, meaning Avalon-ST data.
REQ-012 SHALL have port startofpacket, output, 1, meaning first beat of a packet.
REQ-013 SHALL have port endofpacket, output, 1, meaning last beat of a packet.
REQ-014 SHALL have port busy, output, 1, meaning high while in SEND.
REQ-015 SHALL have port done, output, 1, meaning high while in DONE.
REQ-016 SHALL have port pkt_count, output, 16, meaning packets completed in the current run, wrapping at 2^16.

Function
REQ-017 SHALL implement states IDLE, SEND and DONE; all outputs registered or decoded from registers only (no ready-to-output combinational path).
REQ-018 SHALL count a transfer only in a cycle where valid=1 and ready=1.
REQ-019 SHALL go IDLE->SEND on a rising edge with start=1, with valid=1, startofpacket=1 and data=START_VAL visible in the next cycle.
REQ-020 SHALL hold valid, data, startofpacket and endofpacket stable while valid=1 and ready=0, for any number of cycles.
REQ-021 SHALL present beat k (0-based) of each packet with data=(START_VAL + k*STEP) mod 2^DATA_WIDTH; the beat index resets to 0 at every packet start.
REQ-022 SHALL assert startofpacket only on beat 0 and endofpacket only on beat PKT_LEN-1; for PKT_LEN=1, both on the same beat.
REQ-023 SHALL increment pkt_count on every accepted endofpacket beat.
REQ-024 SHALL, on an accepted endofpacket beat when more packets remain (NUM_PKTS=0, or pkt_count+1 < NUM_PKTS), present the next packet's beat 0 in the following cycle with valid held high (no bubble).
REQ-025 SHALL, on the accepted endofpacket beat of the last packet, go SEND->DONE, with valid=0 from the next cycle.
REQ-026 SHALL ignore start while in SEND.
REQ-027 SHALL, in DONE with start=1, clear pkt_count to 0 and enter SEND, presenting beat 0 in the next cycle.
REQ-028 SHALL drive valid=0, startofpacket=0 and endofpacket=0 in IDLE and DONE; data holds its last value there.

Reset
REQ-029 SHALL, while resetn=0, immediately and independently of clk force state=IDLE, valid=0, startofpacket=0, endofpacket=0, data=0, pkt_count=0, busy=0, done=0.
REQ-030 SHALL, on reset asserted mid-packet, abandon the packet with no further beats until a new start after resetn=1.
REQ-031 SHALL ignore start in the first clk edge after resetn deasserts only if that edge violates recovery time; otherwise start is sampled normally.

Verification
REQ-032 SHALL cover defaults, ready tied high, start pulsed once -> beats 4(sop),5,6(eop) on consecutive cycles, then done=1, pkt_count=1, valid=0.
REQ-033 SHALL cover defaults, ready low for 3 cycles while data=5 is presented -> data=5 with valid=1 held for all 3 cycles, then 6 follows; no beat lost or duplicated.
REQ-034 SHALL cover NUM_PKTS=2, PKT_LEN=2, ready high -> data 4,5,4,5 with sop/eop pattern 10,01,10,01 and no bubble; pkt_count ends at 2.
REQ-035 SHALL cover DATA_WIDTH=4, START_VAL=14, STEP=1, PKT_LEN=4 -> data 14,15,0,1 (wrap).
REQ-036 SHALL cover PKT_LEN=1 -> a single beat with sop=eop=1 and data=START_VAL.
REQ-037 SHALL cover resetn pulsed low during beat 1 of a packet -> valid=0 and pkt_count=0 within the same cycle; no beat after resetn=1 until start, then the sequence restarts at beat 0.

Source files
------------

// File: rtl/avalon_st_seq_source.sv
// Avalon-ST source emitting fixed-length packets of an arithmetic data sequence.
// All outputs come from registers; ready only steers next-state logic.
module avalon_st_seq_source #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 3,
    parameter int unsigned START_VAL  = 4,
    parameter int unsigned STEP       = 1,
    parameter int unsigned NUM_PKTS   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  startofpacket,
    output logic                  endofpacket,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_count
);

    localparam logic [DATA_WIDTH-1:0] FirstVal   = DATA_WIDTH'(START_VAL);
    localparam logic [DATA_WIDTH-1:0] StepVal    = DATA_WIDTH'(STEP);
    localparam logic [7:0]            LastBeat   = 8'(PKT_LEN - 1);
    localparam logic                  SingleBeat = (PKT_LEN == 1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [7:0]            beat_q, beat_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic                  more_pkts;

    // NUM_PKTS of zero means the run never terminates.
    assign more_pkts = (NUM_PKTS == 0) || (({16'd0, pkt_count_q} + 32'd1) < NUM_PKTS);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        data_d      = data_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        beat_d      = beat_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StSend;
                    valid_d     = 1'b1;
                    data_d      = FirstVal;
                    sop_d       = 1'b1;
                    eop_d       = SingleBeat;
                    beat_d      = 8'd0;
                    pkt_count_d = 16'd0;
                end
            end
            StSend: begin
                // valid is always high in SEND, so ready alone marks a transfer.
                if (ready) begin
                    if (eop_q) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        if (more_pkts) begin
                            data_d = FirstVal;
                            sop_d  = 1'b1;
                            eop_d  = SingleBeat;
                            beat_d = 8'd0;
                        end else begin
                            state_d = StDone;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                        data_d = data_q + StepVal;
                        sop_d  = 1'b0;
                        eop_d  = ((beat_q + 8'd1) == LastBeat);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            data_q      <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            beat_q      <= 8'd0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            beat_q      <= beat_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign valid         = valid_q;
    assign data          = data_q;
    assign startofpacket = sop_q;
    assign endofpacket   = eop_q;
    assign busy          = (state_q == StSend);
    assign done          = (state_q == StDone);
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_avalon_st_seq_source.sv
// Scoreboard bench for avalon_st_seq_source across four parameterisations.
module tb_avalon_st_seq_source;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start_r = 1'b0;
    logic ready_r = 1'b0;
    int   sel = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t sb_q[$];

    logic        v [4];
    logic        sp[4];
    logic        ep[4];
    logic        bz[4];
    logic        dn[4];
    logic [15:0] pc[4];
    logic [7:0]  d0, d1, d2;
    logic [3:0]  d3;
    logic        st[4];
    logic        rd[4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            st[k] = (sel == k) ? start_r : 1'b0;
            rd[k] = (sel == k) ? ready_r : 1'b0;
        end
    end

    avalon_st_seq_source u_dut0 (
        .clk(clk), .resetn(resetn), .start(st[0]), .ready(rd[0]), .valid(v[0]), .data(d0),
        .startofpacket(sp[0]), .endofpacket(ep[0]), .busy(bz[0]), .done(dn[0]),
        .pkt_count(pc[0])
    );

    avalon_st_seq_source #(.PKT_LEN(2), .NUM_PKTS(2)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(st[1]), .ready(rd[1]), .valid(v[1]), .data(d1),
        .startofpacket(sp[1]), .endofpacket(ep[1]), .busy(bz[1]), .done(dn[1]),
        .pkt_count(pc[1])
    );

    avalon_st_seq_source #(.PKT_LEN(1)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(st[2]), .ready(rd[2]), .valid(v[2]), .data(d2),
        .startofpacket(sp[2]), .endofpacket(ep[2]), .busy(bz[2]), .done(dn[2]),
        .pkt_count(pc[2])
    );

    avalon_st_seq_source #(.DATA_WIDTH(4), .START_VAL(14), .STEP(1), .PKT_LEN(4)) u_dut3 (
        .clk(clk), .resetn(resetn), .start(st[3]), .ready(rd[3]), .valid(v[3]), .data(d3),
        .startofpacket(sp[3]), .endofpacket(ep[3]), .busy(bz[3]), .done(dn[3]),
        .pkt_count(pc[3])
    );

    logic        o_valid, o_sop, o_eop, o_busy, o_done;
    logic [31:0] o_data;
    logic [15:0] o_pkt;

    always_comb begin
        o_valid = v[sel];
        o_sop   = sp[sel];
        o_eop   = ep[sel];
        o_busy  = bz[sel];
        o_done  = dn[sel];
        o_pkt   = pc[sel];
        case (sel)
            0:       o_data = {24'd0, d0};
            1:       o_data = {24'd0, d1};
            2:       o_data = {24'd0, d2};
            default: o_data = {28'd0, d3};
        endcase
    end

    task automatic push(input logic [31:0] dat, input logic s, input logic e);
        beat_t b;
        b.data = dat;
        b.sop  = s;
        b.eop  = e;
        sb_q.push_back(b);
    endtask

    // Phase convention: every task starts and ends 1 time unit after a rising edge.
    task automatic pulse_start();
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
    endtask

    // Compare every presented beat with the queue head; pop only on acceptance.
    task automatic drain(input string name, input logic [31:0] stall_val, input int stalls);
        int    left = stalls;
        int    cyc = 0;
        logic  rdy;
        beat_t e;
        while (sb_q.size() > 0 && cyc < 50) begin
            e   = sb_q[0];
            rdy = 1'b1;
            if (left > 0 && e.data == stall_val) begin
                rdy = 1'b0;
                left--;
            end
            n_tests++;
            if (o_valid !== 1'b1 || o_data !== e.data || o_sop !== e.sop || o_eop !== e.eop) begin
                n_fail++;
                $display("FAIL %s beat: got v=%b d=%0d sop=%b eop=%b, want v=1 d=%0d sop=%b eop=%b",
                         name, o_valid, o_data, o_sop, o_eop, e.data, e.sop, e.eop);
            end
            ready_r = rdy;
            @(posedge clk);
            #1;
            if (rdy) void'(sb_q.pop_front());
            cyc++;
        end
        ready_r = 1'b0;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: %0d beats still expected, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_done(input string name, input logic [15:0] exp_pkt);
        n_tests++;
        if (o_valid !== 1'b0 || o_done !== 1'b1 || o_busy !== 1'b0 || o_pkt !== exp_pkt) begin
            n_fail++;
            $display("FAIL %s end: got v=%b done=%b busy=%b pkt=%0d, want v=0 done=1 busy=0 pkt=%0d",
                     name, o_valid, o_done, o_busy, o_pkt, exp_pkt);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        #2;
        n_tests++;
        if (o_valid !== 1'b0 || o_sop !== 1'b0 || o_eop !== 1'b0 || o_data !== 32'd0 ||
            o_pkt !== 16'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b sop=%b eop=%b d=%0d pkt=%0d busy=%b done=%b, want all 0",
                     o_valid, o_sop, o_eop, o_data, o_pkt, o_busy, o_done);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) begin
            ready_r = 1'b1;
            @(posedge clk);
            #1;
            n_tests++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_valid: got v=%b, want 0", o_valid);
            end
        end
        ready_r = 1'b0;
    endtask

    task automatic test_basic();
        sel = 0;
        push(4, 1, 0); push(5, 0, 0); push(6, 0, 1);
        pulse_start();
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, want 1", o_busy);
        end
        drain("basic", 0, 0);
        check_done("basic", 16'd1);
    endtask

    task automatic test_stall();
        sel = 0;
        push(4, 1, 0); push(5, 0, 0); push(6, 0, 1);
        pulse_start();
        drain("stall", 32'd5, 3);
        check_done("stall", 16'd1);
    endtask

    // start held through SEND is ignored, then restarts the run from DONE.
    task automatic test_start_in_send();
        sel = 0;
        push(4, 1, 0); push(5, 0, 0); push(6, 0, 1);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        drain("start_held", 0, 0);
        check_done("start_held", 16'd1);
        @(posedge clk);
        #1;
        start_r = 1'b0;
        n_tests++;
        if (o_valid !== 1'b1 || o_pkt !== 16'd0 || o_data !== 32'd4 || o_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got v=%b pkt=%0d d=%0d sop=%b, want v=1 pkt=0 d=4 sop=1",
                     o_valid, o_pkt, o_data, o_sop);
        end
        push(4, 1, 0); push(5, 0, 0); push(6, 0, 1);
        drain("restart", 0, 0);
        check_done("restart", 16'd1);
    endtask

    task automatic test_back_to_back();
        sel = 1;
        push(4, 1, 0); push(5, 0, 1); push(4, 1, 0); push(5, 0, 1);
        pulse_start();
        drain("b2b", 0, 0);
        check_done("b2b", 16'd2);
    endtask

    task automatic test_single_beat();
        sel = 2;
        push(4, 1, 1);
        pulse_start();
        drain("single", 0, 0);
        check_done("single", 16'd1);
    endtask

    task automatic test_wrap();
        sel = 3;
        push(14, 1, 0); push(15, 0, 0); push(0, 0, 0); push(1, 0, 1);
        pulse_start();
        drain("wrap", 0, 0);
        check_done("wrap", 16'd1);
    endtask

    task automatic test_reset_mid_packet();
        sel = 1;
        push(4, 1, 0); push(5, 0, 1); push(4, 1, 0);
        pulse_start();
        drain("pre_reset", 0, 0);
        ready_r = 1'b1;
        n_tests++;
        if (o_data !== 32'd5 || o_pkt !== 16'd1 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_beat1: got d=%0d pkt=%0d v=%b, want d=5 pkt=1 v=1",
                     o_data, o_pkt, o_valid);
        end
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_pkt !== 16'd0 || o_sop !== 1'b0 || o_eop !== 1'b0 ||
            o_data !== 32'd0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b pkt=%0d sop=%b eop=%b d=%0d busy=%b, want all 0",
                     o_valid, o_pkt, o_sop, o_eop, o_data, o_busy);
        end
        #1;
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet: got v=%b busy=%b, want v=0 busy=0", o_valid, o_busy);
            end
        end
        ready_r = 1'b0;
        push(4, 1, 0); push(5, 0, 1); push(4, 1, 0); push(5, 0, 1);
        pulse_start();
        drain("post_reset", 0, 0);
        check_done("post_reset", 16'd2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_in_send();
        test_back_to_back();
        test_single_beat();
        test_wrap();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
